gray_ptr_rx: RTL and testbench

Receive side of a Gray-coded pointer link. Samples a Gray-coded write pointer that has already been synchronized into this clock domain, decodes it to binary, and converts each forward step into credits. Credits are drained one per handshake. The block is the consumer counterpart to a `binary_to_gray` pointer source. It sits at the read end of CDC FIFOs and credit-return paths, and flags illegal pointer movement.

---
 rtl/gray_ptr_rx_pkg.sv | 16 +
 rtl/gray_to_binary.sv | 17 +
 rtl/gray_ptr_rx.sv | 113 +++++++++++
 tb/tb_gray_ptr_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_ptr_rx_pkg.sv
// Shared types and helpers for the Gray-coded pointer receiver.
package gray_ptr_rx_pkg;

  // The credit counter must hold 0..2**n inclusive, so it needs one bit more than the pointer.
  function automatic int cnt_w(input int n);
    return n + 1;
  endfunction

  // Sticky error flags kept by the receiver.
  typedef struct packed {
    logic step;
    logic ovf;
    logic ham;
  } err_t;

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_binary #(
  parameter int N = 4
) (
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o
);

  // Prefix-XOR from the MSB down, written as a reduction to avoid a self-referencing loop.
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < N; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/gray_ptr_rx.sv
// Receive side of a Gray-coded pointer link: turns forward pointer steps into credits that are
// drained one per pop handshake, and flags illegal pointer movement with sticky errors.
// Optional feature: define GRAY_PTR_RX_HAMMING_CHECK_EN to flag samples where more than one Gray
// bit changed between consecutive cycles (only meaningful if the source clock is not faster).
module gray_ptr_rx
  import gray_ptr_rx_pkg::*;
#(
  parameter int N       = 4,
  parameter int MaxStep = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N-1:0]        gray_i,
  input  logic                clr_i,
  output logic                pop_valid_o,
  input  logic                pop_ready_i,
  output logic [cnt_w(N)-1:0] count_o,
  output logic [N-1:0]        ptr_o,
  output logic                err_step_o,
  output logic                err_ovf_o,
  output logic                err_ham_o
);

  localparam int              CW       = cnt_w(N);
  localparam logic [N-1:0]    MAX_STEP = N'(MaxStep);
  localparam logic [N+1:0]    FULL     = (N+2)'(2**N);

  logic [N-1:0]  gray_q;
  logic [N-1:0]  bin;
  logic [N-1:0]  delta;
  logic [N-1:0]  acc;
  logic [N-1:0]  ptr_q, ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [N+1:0]  count_sum;
  logic          valid_q, valid_d;
  logic          pop;
  err_t          err_q, err_d, err_new;

  gray_to_binary #(.N(N)) u_dec (
    .gray_i (gray_q),
    .bin_o  (bin)
  );

`ifdef GRAY_PTR_RX_HAMMING_CHECK_EN
  logic [N-1:0] gray_prev_q;

  // Keep the previous stage-1 sample so single-bit Gray movement can be verified.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) gray_prev_q <= '0;
    else         gray_prev_q <= gray_q;
  end
`endif

  // Accept rule, credit accounting with saturation, and sticky-error update.
  always_comb begin
    err_new = '0;
    acc     = '0;
    ptr_d   = ptr_q;
    delta   = bin - ptr_q;
    pop     = valid_q & pop_ready_i;

    if (delta > MAX_STEP) begin
      err_new.step = 1'b1;
    end else if (delta != '0) begin
      acc   = delta;
      ptr_d = bin;
    end

    count_sum = {1'b0, count_q} + {2'b00, acc} - {{(N+1){1'b0}}, pop};
    if (count_sum > FULL) begin
      count_d     = FULL[CW-1:0];
      err_new.ovf = 1'b1;
    end else begin
      count_d = count_sum[CW-1:0];
    end
    valid_d = (count_d != '0);

`ifdef GRAY_PTR_RX_HAMMING_CHECK_EN
    err_new.ham = ($countones(gray_q ^ gray_prev_q) > 1);
`endif

    // A fresh error in the clearing cycle survives the clear.
    err_d = err_new | (clr_i ? err_t'('0) : err_q);
`ifndef GRAY_PTR_RX_HAMMING_CHECK_EN
    err_d.ham = 1'b0;
`endif
  end

  // Pipeline and state registers; reset discards credits and pointer in one step.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      gray_q  <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      err_q   <= '0;
    end else begin
      gray_q  <= gray_i;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign pop_valid_o = valid_q;
  assign count_o     = count_q;
  assign ptr_o       = ptr_q;
  assign err_step_o  = err_q.step;
  assign err_ovf_o   = err_q.ovf;
  assign err_ham_o   = err_q.ham;

endmodule

// File: tb/tb_gray_ptr_rx.sv
// Scoreboard bench for gray_ptr_rx: the stimulus side advances an arithmetic model of the
// credit link and queues the expected outputs; a monitor compares them after every clock edge.
module tb_gray_ptr_rx;

  localparam int N       = 4;
  localparam int MaxStep = 4;
  localparam int SPACE   = 2**N;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic [N-1:0]   gray_i = '0;
  logic           clr_i = 1'b0;
  logic           pop_valid_o;
  logic           pop_ready_i = 1'b0;
  logic [N:0]     count_o;
  logic [N-1:0]   ptr_o;
  logic           err_step_o;
  logic           err_ovf_o;
  logic           err_ham_o;

  int tests = 0;
  int fails = 0;

  gray_ptr_rx #(.N(N), .MaxStep(MaxStep)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .gray_i      (gray_i),
    .clr_i       (clr_i),
    .pop_valid_o (pop_valid_o),
    .pop_ready_i (pop_ready_i),
    .count_o     (count_o),
    .ptr_o       (ptr_o),
    .err_step_o  (err_step_o),
    .err_ovf_o   (err_ovf_o),
    .err_ham_o   (err_ham_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int ptr;
    int cnt;
    bit v;
    bit es;
    bit eo;
    bit eh;
  } exp_t;

  exp_t exp_q[$];

  // Model state: remote pointer seen one edge ago (s1), the one before (s1p), local pointer,
  // credits and sticky flags.
  int m_s1 = 0, m_s1p = 0, m_ptr = 0, m_cnt = 0;
  bit m_es = 0, m_eo = 0, m_eh = 0;

  function automatic logic [N-1:0] to_gray(input int v);
    logic [N-1:0] b;
    b = N'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, advance the model across the coming edge, queue result.
  task automatic step(input int nxt, input bit rdy, input bit clr, input bit rst);
    int delta, acc, c;
    bit pop, n_es, n_eo, n_eh;
    @(negedge clk_i);
    gray_i      = to_gray(nxt);
    pop_ready_i = rdy;
    clr_i       = clr;
    rst_ni      = ~rst;
    if (rst) begin
      m_s1 = 0; m_s1p = 0; m_ptr = 0; m_cnt = 0;
      m_es = 0; m_eo = 0; m_eh = 0;
    end else begin
      delta = (m_s1 - m_ptr + SPACE) % SPACE;
      pop   = rdy && (m_cnt != 0);
      n_es  = (delta > MaxStep);
      acc   = (delta >= 1 && delta <= MaxStep) ? delta : 0;
      if (acc != 0) m_ptr = m_s1;
      c    = m_cnt + acc - (pop ? 1 : 0);
      n_eo = (c > SPACE);
      if (n_eo) c = SPACE;
      m_cnt = c;
`ifdef GRAY_PTR_RX_HAMMING_CHECK_EN
      n_eh = ($countones(to_gray(m_s1) ^ to_gray(m_s1p)) > 1);
`else
      n_eh = 1'b0;
`endif
      m_es = n_es | (m_es & ~clr);
      m_eo = n_eo | (m_eo & ~clr);
      m_eh = n_eh | (m_eh & ~clr);
      m_s1p = m_s1;
      m_s1  = nxt % SPACE;
    end
    exp_q.push_back('{ptr: m_ptr, cnt: m_cnt, v: (m_cnt != 0), es: m_es, eo: m_eo, eh: m_eh});
    @(posedge clk_i);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation after each edge.
  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ptr_o",       int'(ptr_o),       e.ptr);
      chk("count_o",     int'(count_o),     e.cnt);
      chk("pop_valid_o", int'(pop_valid_o), int'(e.v));
      chk("err_step_o",  int'(err_step_o),  int'(e.es));
      chk("err_ovf_o",   int'(err_ovf_o),   int'(e.eo));
      chk("err_ham_o",   int'(err_ham_o),   int'(e.eh));
    end
  end

  initial begin
    int p, r, nxt, guard;
    bit rst;

    // Reset with idle pointer.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    #2;
    chk("reset count", int'(count_o), 0);
    chk("reset ptr", int'(ptr_o), 0);
    chk("reset valid", int'(pop_valid_o), 0);
    chk("reset errs", int'({err_step_o, err_ovf_o, err_ham_o}), 0);

    // 0->1->2->3 without popping.
    step(1, 0, 0, 0);
    step(2, 0, 0, 0);
    step(3, 0, 0, 0);
    step(3, 0, 0, 0);
    step(3, 0, 0, 0);
    #2;
    chk("seq3 count", int'(count_o), 3);
    chk("seq3 ptr", int'(ptr_o), 3);
    for (int i = 0; i < 4; i++) step(3, 1, 0, 0);
    #2;
    chk("drain count", int'(count_o), 0);

    // Full lap with continuous popping, including the 15->0 wrap.
    for (int i = 4; i <= 16; i++) step(i % SPACE, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    #2;
    chk("lap errs", int'({err_step_o, err_ovf_o, err_ham_o}), 0);
    chk("lap count", int'(count_o), 0);
    chk("lap ptr", int'(ptr_o), 0);

    // Illegal jump 2 -> 9.
    for (int i = 0; i < 4; i++) step(2, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(9, 0, 0, 0);
    #2;
    chk("jump err_step", int'(err_step_o), 1);
    chk("jump ptr", int'(ptr_o), 2);
    chk("jump count", int'(count_o), 0);
    step(2, 0, 0, 0);
    step(2, 0, 0, 0);
    step(2, 0, 1, 0);
    #2;
    chk("clr err_step", int'(err_step_o), 0);

    // Sixteen steps fill the counter, the seventeenth overflows.
    p = 2;
    for (int i = 0; i < 16; i++) begin p = (p + 1) % SPACE; step(p, 0, 0, 0); end
    step(p, 0, 0, 0);
    step(p, 0, 0, 0);
    #2;
    chk("full count", int'(count_o), 16);
    chk("full no ovf", int'(err_ovf_o), 0);
    p = (p + 1) % SPACE;
    step(p, 0, 0, 0);
    step(p, 0, 0, 0);
    step(p, 0, 0, 0);
    #2;
    chk("ovf count", int'(count_o), 16);
    chk("ovf flag", int'(err_ovf_o), 1);
    p = (p + 1) % SPACE;
    step(p, 0, 0, 0);
    step(p, 1, 0, 0);
    step(p, 0, 0, 0);
    #2;
    chk("pop+inc count", int'(count_o), 16);

    // Two Gray bits flip at once (0000 -> 0011).
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(2, 0, 0, 0);
    #2;
`ifdef GRAY_PTR_RX_HAMMING_CHECK_EN
    chk("ham flag", int'(err_ham_o), 1);
`else
    chk("ham flag", int'(err_ham_o), 0);
`endif
    chk("ham count", int'(count_o), 2);

    // Randomized traffic with occasional clears, resets and illegal moves.
    p = 2;
    for (int i = 0; i < 3000; i++) begin
      r   = $urandom_range(0, 99);
      rst = ($urandom_range(0, 199) == 0);
      if (r < 65)      nxt = (p + $urandom_range(0, MaxStep)) % SPACE;
      else if (r < 78) nxt = p;
      else if (r < 86) nxt = $urandom_range(0, SPACE - 1);
      else if (r < 93) nxt = (p - $urandom_range(1, 3) + SPACE) % SPACE;
      else             nxt = m_ptr;
      if (rst) nxt = 0;
      p = nxt;
      step(nxt, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, rst);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk_i);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
